// File: rtl/program_loader_if.sv
// Host-link byte stream and program-memory write bus for program_loader.
// The loader connects through the slave modport; the host/memory side uses master.
interface program_loader_if #(
  parameter int COMMAND_SIZE = 33,
  parameter int ADDR_WIDTH   = 10
);
  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    rearm;
  logic                    prog_we;
  logic [ADDR_WIDTH-1:0]   prog_addr;
  logic [COMMAND_SIZE-1:0] prog_wdata;
  logic [ADDR_WIDTH:0]     words_loaded;
  logic                    cpu_hold;
  logic                    done;
  logic                    err;

  modport master (
    output in_data, in_valid, rearm,
    input  in_ready, prog_we, prog_addr, prog_wdata, words_loaded, cpu_hold, done, err
  );

  modport slave (
    input  in_data, in_valid, rearm,
    output in_ready, prog_we, prog_addr, prog_wdata, words_loaded, cpu_hold, done, err
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: writer side of the CPU instruction memory.
// Accepts a frame  START_BYTE, LEN_HI, LEN_LO, N x 5 data bytes  from a
// valid/ready byte stream, packs every 5 bytes (MSB first) into one
// COMMAND_SIZE-bit word and writes it to program memory. The CPU is held in
// reset (cpu_hold) until a complete image has been written.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte covering the length and data bytes.
module program_loader #(
  parameter int         COMMAND_SIZE = 33,
  parameter int         ADDR_WIDTH   = 10,
  parameter int         PROGRAM_SIZE = 1024,
  parameter logic [7:0] START_BYTE   = 8'hA5
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

  localparam logic [16:0] LEN_LIMIT = 17'(PROGRAM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              len_hi_q, len_hi_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [2:0]              byte_idx_q, byte_idx_d;
  logic [COMMAND_SIZE-9:0] shift_q, shift_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [COMMAND_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]     loaded_q, loaded_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    hold_q, hold_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  logic                    fire;
  logic [15:0]             len_full;
  logic [COMMAND_SIZE-1:0] word_next;

  // Only the low COMMAND_SIZE bits of the 40-bit assembly are ever kept, so
  // the upper byte bits fall off the top of the shifter naturally.
  assign fire      = bus.in_valid && ready_q;
  assign len_full  = {len_hi_q, bus.in_data};
  assign word_next = {shift_q, bus.in_data};

  assign bus.in_ready     = ready_q;
  assign bus.prog_we      = we_q;
  assign bus.prog_addr    = addr_q;
  assign bus.prog_wdata   = wdata_q;
  assign bus.words_loaded = loaded_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.cpu_hold     = hold_q;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_hi_q   <= '0;
      count_q    <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      loaded_q   <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      loaded_q   <= loaded_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic; status outputs are derived from the next state.
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    loaded_d   = loaded_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (fire && bus.in_data == START_BYTE) begin
          state_d = S_LEN_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end

      S_LEN_HI: begin
        if (fire) begin
          len_hi_d = bus.in_data;
          state_d  = S_LEN_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ bus.in_data;
`endif
        end
      end

      S_LEN_LO: begin
        if (fire) begin
          loaded_d   = '0;
          byte_idx_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.in_data;
`endif
          if (len_full == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_full} > LEN_LIMIT) begin
            state_d = S_ERROR;
          end else begin
            count_d = len_full[ADDR_WIDTH:0];
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        // The write cycle of the final word is where LOAD hands off. in_ready
        // is still high there, so a trailing checksum byte may already arrive.
        if (loaded_q == count_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (fire) begin
            state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
          end else begin
            state_d = S_CSUM;
          end
`else
          state_d = S_DONE;
`endif
        end else if (fire) begin
          shift_d = word_next[COMMAND_SIZE-9:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
          if (byte_idx_q == 3'd4) begin
            we_d       = 1'b1;
            addr_d     = loaded_q[ADDR_WIDTH-1:0];
            wdata_d    = word_next;
            loaded_d   = loaded_q + 1'b1;
            byte_idx_d = '0;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (fire) begin
          state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif

      S_DONE, S_ERROR: begin
        if (bus.rearm) begin
          state_d  = S_IDLE;
          loaded_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = !(state_d == S_DONE || state_d == S_ERROR);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERROR);
    hold_d  = (state_d != S_DONE);
  end

endmodule
